sample_scheduler: RTL and testbench

Sits between the Pico SPI receiver (its one-cycle data-ready pulse) and the DAC SPI driver inside the pedal top level. Buffers incoming 16-bit samples in a small FIFO and issues them to the DAC driver on a fixed sample-rate tick, using a request/busy handshake. Decouples the jittery arrival of SPI words from the constant DAC output rate. Also reports underrun, overflow and late-tick status.

---
 rtl/pedal_pkg.sv | 6 +
 rtl/sync_fifo.sv | 36 +++
 rtl/sample_scheduler.sv | 84 ++++++++
 tb/tb_sample_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// pedal_pkg: shared sample type, scheduler states and clock constant for the pedal audio path
package pedal_pkg;
  typedef logic [15:0] sample_t;
  typedef enum logic [2:0] {PREFILL, WAIT_TICK, LOAD, REQ, BUSY} sched_state_t;
  localparam int CLK_HZ_DEFAULT = 25000000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through sample FIFO; a write into a full FIFO succeeds only alongside a read
module sync_fifo import pedal_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  sample_t                  wr_data,
  input  logic                     rd_en,
  output sample_t                  rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  sample_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty = level == '0;
  assign full = level[AW];
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: buffers SPI samples and hands them to the DAC driver on a fixed sample-rate tick
module sample_scheduler import pedal_pkg::*; #(
  parameter int CLK_HZ         = CLK_HZ_DEFAULT,
  parameter int SAMPLE_HZ      = 48000,
  parameter int DEPTH          = 8,
  parameter int PREFILL        = 4,
  parameter int UNDERRUN_LIMIT = 16
) (
  input  logic                   clk_25mhz,
  input  logic                   reset,
  input  logic [15:0]            in_sample,
  input  logic                   in_valid,
  output logic [15:0]            dac_data,
  output logic                   dac_start,
  input  logic                   dac_busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   playing,
  output logic                   underrun,
  output logic                   overflow,
  output logic                   late_tick,
  input  logic                   clear_flags
);
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DIV + 1);
  localparam int UW = $clog2(UNDERRUN_LIMIT + 1);
  sched_state_t state, state_n;
  logic [DW-1:0] div;
  logic [UW-1:0] run, run_inc;
  logic tick, pending, consume, pop, starve, give_up, full, empty;
  sample_t head;
  assign tick = div == DW'(DIV - 1);
  assign consume = state == WAIT_TICK && pending;
  assign pop = state == LOAD && !empty;
  assign starve = state == LOAD && empty;
  assign run_inc = run + 1'b1;
  assign give_up = starve && run_inc == UW'(UNDERRUN_LIMIT);
  assign playing = state != pedal_pkg::PREFILL;
  assign dac_start = state == REQ;
  sync_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk_25mhz),
    .rst(reset),
    .wr_en(in_valid),
    .wr_data(in_sample),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk_25mhz or posedge reset)
    if (reset) state <= pedal_pkg::PREFILL;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      pedal_pkg::PREFILL: state_n = fifo_level >= LW'(PREFILL) ? WAIT_TICK : state;
      WAIT_TICK: state_n = pending ? LOAD : state;
      LOAD: state_n = give_up ? pedal_pkg::PREFILL : REQ;
      REQ: state_n = dac_busy ? BUSY : state;
      BUSY: state_n = dac_busy ? state : WAIT_TICK;
      default: state_n = pedal_pkg::PREFILL;
    endcase
  end
  // Ticks seen while prefilling are dropped, so pending only lives while playing.
  always_ff @(posedge clk_25mhz or posedge reset)
    if (reset) begin
      div <= '0;
      pending <= 1'b0;
      run <= '0;
      dac_data <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      late_tick <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      pending <= playing && (consume ? tick : (pending || tick));
      run <= (pop || give_up) ? '0 : starve ? run_inc : run;
      dac_data <= give_up ? '0 : pop ? head : dac_data;
      underrun <= starve || (underrun && !clear_flags);
      overflow <= (in_valid && full && !pop) || (overflow && !clear_flags);
      late_tick <= (playing && tick && pending && !consume) || (late_tick && !clear_flags);
    end
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed stimulus with a frame scoreboard checked by a DAC-side monitor
module tb_sample_scheduler;
  logic clk, reset, in_valid, dac_start, dac_busy, playing, underrun, overflow, late_tick, clear_flags;
  logic [15:0] in_sample, dac_data;
  logic [3:0] fifo_level;
  int compared, mismatched, frames, busy_len, dcnt, cyc, last_start;
  bit gap_on, prev_start;
  logic [15:0] sb [$];

  sample_scheduler dut (
    .clk_25mhz(clk),
    .reset(reset),
    .in_sample(in_sample),
    .in_valid(in_valid),
    .dac_data(dac_data),
    .dac_start(dac_start),
    .dac_busy(dac_busy),
    .fifo_level(fifo_level),
    .playing(playing),
    .underrun(underrun),
    .overflow(overflow),
    .late_tick(late_tick),
    .clear_flags(clear_flags)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DAC driver model: accepts a request at once, stays busy for busy_len+1 cycles
  always @(negedge clk) begin
    if (reset) begin
      dac_busy = 0;
      dcnt = 0;
    end else if (dac_busy) begin
      if (dcnt == 0) dac_busy = 0;
      else dcnt--;
    end else if (dac_start) begin
      dac_busy = 1;
      dcnt = busy_len;
    end
  end

  always @(negedge clk) begin
    if (dac_start && !prev_start) begin
      frames++;
      if (sb.size() == 0) chk("frame_unexpected", {16'h0, dac_data}, 32'hffff_ffff);
      else chk("frame_data", {16'h0, dac_data}, {16'h0, sb.pop_front()});
      if (gap_on && last_start != 0) chk("tick_gap", cyc - last_start, 520);
      last_start = cyc;
    end
    prev_start = dac_start;
  end

  task automatic push(input logic [15:0] v, input bit expect_out);
    in_sample = v;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    if (expect_out) sb.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    in_valid = 0;
    clear_flags = 0;
    repeat (2) @(negedge clk);
    sb.delete();
    frames = 0;
    last_start = 0;
    reset = 0;
  endtask

  task automatic wait_frames(input int n, input int lim);
    int i = 0;
    while (frames < n && i < lim) begin @(negedge clk); i++; end
    chk("wait_frames", frames >= n, 1);
  endtask

  task automatic wait_idle(input int lim);
    int i = 0;
    while (playing && i < lim) begin @(negedge clk); i++; end
    chk("wait_prefill", playing, 0);
  endtask

  task automatic wait_drained(input int lim);
    int i = 0;
    while (sb.size() != 0 && i < lim) begin @(negedge clk); i++; end
    chk("wait_drained", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    compared = 0; mismatched = 0; frames = 0; last_start = 0;
    reset = 1; in_valid = 0; in_sample = 0; clear_flags = 0; busy_len = 3; gap_on = 0;
    repeat (3) @(negedge clk);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_dac_start", dac_start, 0);
    chk("rst_playing", playing, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_flags", {underrun, overflow, late_tick}, 0);
    reset = 0;
    // prefill, play four samples, then starve until the scheduler falls back
    gap_on = 1;
    for (int i = 1; i <= 4; i++) push(16'(i), 1);
    chk("prefill_level", fifo_level, 4);
    chk("playing_before", playing, 0);
    @(negedge clk);
    chk("playing_after", playing, 1);
    repeat (15) sb.push_back(16'h0004);
    wait_frames(5, 3500);
    chk("underrun_set", underrun, 1);
    wait_idle(10000);
    chk("fallback_data", dac_data, 0);
    chk("fallback_level", fifo_level, 0);
    chk("starve_frames", frames, 19);
    chk("starve_late", late_tick, 0);
    chk("starve_overflow", overflow, 0);
    clear_flags = 1;
    @(negedge clk);
    clear_flags = 0;
    chk("clear_underrun", underrun, 0);
    gap_on = 0;
    // overflow on the ninth word, then one frame held busy across two ticks
    do_reset();
    for (int i = 0; i < 9; i++) push(16'(16'h0011 + i), i < 8);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_flag", overflow, 1);
    @(posedge dac_busy);
    busy_len = 1040;
    @(negedge dac_busy);
    @(posedge dac_busy);
    busy_len = 3;
    wait_drained(6000);
    chk("late_flag", late_tick, 1);
    chk("late_frames", frames, 8);
    chk("late_overflow_kept", overflow, 1);
    // write into a full FIFO on the very cycle of the first pop
    do_reset();
    for (int i = 0; i < 8; i++) push(16'(16'h0021 + i), 1);
    while (cyc != 521) @(negedge clk);
    chk("full_before_pop", fifo_level, 8);
    in_sample = 16'h0029;
    in_valid = 1;
    sb.push_back(16'h0029);
    @(negedge clk);
    in_valid = 0;
    chk("pop_write_level", fifo_level, 8);
    chk("pop_write_overflow", overflow, 0);
    chk("req_active", dac_start, 1);
    // reset lands mid-request
    #1 reset = 1;
    #1;
    chk("async_dac_start", dac_start, 0);
    chk("async_level", fifo_level, 0);
    chk("async_playing", playing, 0);
    chk("async_dac_data", dac_data, 0);
    chk("async_flags", {underrun, overflow, late_tick}, 0);
    @(negedge clk);
    sb.delete();
    frames = 0;
    last_start = 0;
    reset = 0;
    for (int i = 0; i < 8; i++) push(16'(16'h0031 + i), 0);
    in_sample = 16'h0039;
    in_valid = 1;
    clear_flags = 1;
    @(negedge clk);
    in_valid = 0;
    clear_flags = 0;
    chk("set_beats_clear", overflow, 1);
    chk("set_beats_level", fifo_level, 8);
    clear_flags = 1;
    @(negedge clk);
    clear_flags = 0;
    chk("clear_overflow", overflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
